// File: rtl/cmd_frame_decoder_pkg.sv
// Shared command codes, FSM encoding and frame classification for the command frame decoder.
package cmd_frame_decoder_pkg;

  localparam int RSVD_W = 5;
  localparam int CMD_W  = 3;

  localparam logic [CMD_W-1:0] CMD_WREQ = 3'd2;
  localparam logic [CMD_W-1:0] CMD_RREQ = 3'd3;
  localparam logic [CMD_W-1:0] CMD_RRES = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RES  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_WREQ = 2'd0,
    CLS_RREQ = 2'd1,
    CLS_RRES = 2'd2,
    CLS_BAD  = 2'd3
  } cls_t;

  function automatic cls_t classify(input logic [CMD_W-1:0] cmd);
    case (cmd)
      CMD_WREQ: classify = CLS_WREQ;
      CMD_RREQ: classify = CLS_RREQ;
      CMD_RRES: classify = CLS_RRES;
      default:  classify = CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_decoder_frame_fifo.sv
// Synchronous FIFO with a first-word-fall-through head; pointers wrap naturally,
// the occupancy count is one bit wider so full and empty are distinguishable.
module frame_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Buffers assembled frames and routes each by command: requests to the APB master,
// read responses to the response sink, unknown commands to a pulse and saturating counter.
module cmd_frame_decoder
  import cmd_frame_decoder_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8,
  localparam int FRAME_W   = RSVD_W + CMD_W + ADDR_W + DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [FRAME_W-1:0]   i_frame_in,
  input  logic                 i_frame_valid,
  output logic                 o_frame_ready,
  output logic                 o_req_valid,
  input  logic                 i_req_ready,
  output logic                 o_req_wr,
  output logic [ADDR_W-1:0]    o_req_addr,
  output logic [DATA_W-1:0]    o_req_data,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [DATA_W-1:0]    o_res_data,
  output logic                 o_err_pulse,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  logic [FRAME_W-1:0]   w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_free;
  cls_t                 w_cls;
  logic [ADDR_W-1:0]    w_head_addr;
  logic [DATA_W-1:0]    w_head_data;
  logic                 w_unused_rsvd;
  state_t               r_state;
  state_t               w_next_state;

  logic                 r_req_wr;
  logic [ADDR_W-1:0]    r_req_addr;
  logic [DATA_W-1:0]    r_req_data;
  logic [DATA_W-1:0]    r_res_data;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign o_frame_ready = ~w_full;
  assign w_push        = i_frame_valid & ~w_full;

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_frame_in),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cls         = classify(w_head[ADDR_W+DATA_W +: CMD_W]);
  assign w_head_addr   = w_head[DATA_W +: ADDR_W];
  assign w_head_data   = w_head[DATA_W-1:0];
  assign w_unused_rsvd = ^w_head[FRAME_W-1 -: RSVD_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // The holding slot frees on a handshake, so the next head is taken in that same cycle.
  always_comb begin
    w_next_state = r_state;
    w_free       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: w_free = 1'b1;
      ST_REQ:  w_free = i_req_ready;
      ST_RES:  w_free = i_res_ready;
      default: w_free = 1'b1;
    endcase
    w_pop = w_free & ~w_empty;
    if (w_pop) begin
      case (w_cls)
        CLS_WREQ, CLS_RREQ: w_next_state = ST_REQ;
        CLS_RRES:           w_next_state = ST_RES;
        default:            w_next_state = ST_IDLE;
      endcase
    end else if (w_free) begin
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_wr    <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_res_data  <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_pop & (w_cls == CLS_BAD);
      if (w_pop) begin
        case (w_cls)
          CLS_WREQ: begin
            r_req_wr   <= 1'b1;
            r_req_addr <= w_head_addr;
            r_req_data <= w_head_data;
          end
          CLS_RREQ: begin
            r_req_wr   <= 1'b0;
            r_req_addr <= w_head_addr;
            r_req_data <= '0;
          end
          CLS_RRES: r_res_data <= w_head_data;
          default: begin
            if (r_err_count != {ERR_CNT_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
          end
        endcase
      end
    end
  end

  assign o_req_valid = (r_state == ST_REQ);
  assign o_res_valid = (r_state == ST_RES);
  assign o_req_wr    = r_req_wr;
  assign o_req_addr  = r_req_addr;
  assign o_req_data  = r_req_data;
  assign o_res_data  = r_res_data;
  assign o_err_pulse = r_err_pulse;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder with hand-computed expectations.
module tb_cmd_frame_decoder;

  logic        clk;
  logic        rst_n;
  logic [55:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        err_pulse;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_err    = 0;

  cmd_frame_decoder dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_in    (frame_in),
    .i_frame_valid (frame_valid),
    .o_frame_ready (frame_ready),
    .o_req_valid   (req_valid),
    .i_req_ready   (req_ready),
    .o_req_wr      (req_wr),
    .o_req_addr    (req_addr),
    .o_req_data    (req_data),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_data    (res_data),
    .o_err_pulse   (err_pulse),
    .o_err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] mk(input logic [4:0] rsvd, input logic [2:0] cmd,
                                     input logic [15:0] a, input logic [31:0] d);
    return {rsvd, cmd, a, d};
  endfunction

  int pulses;
  int bad;
  int stale;

  initial begin
    rst_n       = 1'b0;
    frame_in    = '0;
    frame_valid = 1'b0;
    req_ready   = 1'b0;
    res_ready   = 1'b0;
    repeat (3) tick();
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);

    // 1: reset release with idle inputs
    rst_n = 1'b1;
    tick();
    check("t1_req_valid",   64'(req_valid),   64'd0);
    check("t1_res_valid",   64'(res_valid),   64'd0);
    check("t1_err_pulse",   64'(err_pulse),   64'd0);
    check("t1_err_count",   64'(err_count),   64'd0);
    check("t1_req_wr",      64'(req_wr),      64'd0);
    check("t1_req_addr",    64'(req_addr),    64'd0);
    check("t1_req_data",    64'(req_data),    64'd0);
    check("t1_res_data",    64'(res_data),    64'd0);
    check("t1_frame_ready", 64'(frame_ready), 64'd1);

    // 2: single write request, sink always ready
    req_ready   = 1'b1;
    frame_in    = mk(5'h0, 3'd2, 16'h00A4, 32'hDEADBEEF);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    check("t2_lat_req_valid", 64'(req_valid), 64'd0);
    tick();
    check("t2_req_valid", 64'(req_valid), 64'd1);
    check("t2_req_wr",    64'(req_wr),    64'd1);
    check("t2_req_addr",  64'(req_addr),  64'h00A4);
    check("t2_req_data",  64'(req_data),  64'hDEADBEEF);
    check("t2_res_valid", 64'(res_valid), 64'd0);
    tick();
    check("t2_req_drop",  64'(req_valid), 64'd0);
    check("t2_addr_hold", 64'(req_addr),  64'h00A4);

    // 3: read request stalled, then read response
    req_ready   = 1'b0;
    res_ready   = 1'b0;
    frame_in    = mk(5'h0, 3'd3, 16'h0010, 32'hFFFFFFFF);
    frame_valid = 1'b1;
    tick();
    frame_in    = mk(5'h0, 3'd4, 16'h0000, 32'h12345678);
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_req_valid", 64'(req_valid), 64'd1);
      check("t3_req_wr",    64'(req_wr),    64'd0);
      check("t3_req_addr",  64'(req_addr),  64'h0010);
      check("t3_req_data",  64'(req_data),  64'd0);
      check("t3_res_valid", 64'(res_valid), 64'd0);
      tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("t3_req_after", 64'(req_valid), 64'd0);
    check("t3_res_valid", 64'(res_valid), 64'd1);
    check("t3_res_data",  64'(res_data),  64'h12345678);
    res_ready = 1'b1;
    tick();
    check("t3_res_drop",  64'(res_valid), 64'd0);
    check("t3_res_hold",  64'(res_data),  64'h12345678);
    res_ready = 1'b0;

    // 4: fill FIFO plus holding slot, then drain back-to-back
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_frame_ready", 64'(frame_ready), 64'd1);
      frame_in    = mk(5'h1F, 3'd2, 16'(i + 1), 32'hA0000000 + 32'(i));
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    check("t4_full_ready", 64'(frame_ready), 64'd0);
    check("t4_held_valid", 64'(req_valid),   64'd1);
    req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) check("t4_full_on_pop", 64'(frame_ready), 64'd0);
      check("t4_drain_valid", 64'(req_valid), 64'd1);
      check("t4_drain_addr",  64'(req_addr),  64'(i + 1));
      check("t4_drain_data",  64'(req_data),  64'(32'hA0000000 + 32'(i)));
      tick();
    end
    check("t4_empty_valid", 64'(req_valid),   64'd0);
    check("t4_ready_back",  64'(frame_ready), 64'd1);

    // 5: 256 unknown commands saturate the counter
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 256; i++) begin
      frame_in    = mk(5'h0, 3'd7, 16'(i), 32'h0);
      frame_valid = 1'b1;
      tick();
      if (err_pulse) pulses++;
      if (req_valid || res_valid) bad++;
      if (i == 10) check("t5_count_mid", 64'(err_count), 64'd10);
    end
    frame_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (err_pulse) pulses++;
      if (req_valid || res_valid) bad++;
    end
    check("t5_pulses",     64'(pulses),    64'd256);
    check("t5_err_count",  64'(err_count), 64'hFF);
    check("t5_no_valid",   64'(bad),       64'd0);
    check("t5_pulse_idle", 64'(err_pulse), 64'd0);

    // 6: reset with frames buffered and a request pending
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_in    = mk(5'h0, 3'd2, 16'h00B0 + 16'(i), 32'h0);
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    check("t6_pre_valid", 64'(req_valid), 64'd1);
    check("t6_pre_addr",  64'(req_addr),  64'h00B0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req_valid", 64'(req_valid), 64'd0);
    check("t6_rst_req_addr",  64'(req_addr),  64'd0);
    check("t6_rst_req_wr",    64'(req_wr),    64'd0);
    check("t6_rst_err_count", 64'(err_count), 64'd0);
    tick();
    rst_n     = 1'b1;
    req_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (req_valid || res_valid || err_pulse) stale++;
    end
    check("t6_no_stale",     64'(stale),       64'd0);
    check("t6_frame_ready",  64'(frame_ready), 64'd1);
    frame_in    = mk(5'h0, 3'd2, 16'h0777, 32'h00000777);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    check("t6_fresh_valid", 64'(req_valid), 64'd1);
    check("t6_fresh_addr",  64'(req_addr),  64'h0777);
    check("t6_fresh_data",  64'(req_data),  64'h00000777);
    tick();
    check("t6_fresh_drop",  64'(req_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
